// File: rtl/stack_pkg.sv
// Shared definitions for the data-stack reader and writer sides.
package stack_pkg;
    localparam int STACK_DATA_W = 32;
    localparam int STACK_DEPTH  = 10;
    localparam int STACK_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PRESENT = 2'd2,
        SETTLE  = 2'd3
    } stack_pop_state_t;
endpackage

// File: rtl/stack_pop_ctrl.sv
// Unwinds N entries from the LIFO data stack and streams them over valid/ready.
// Optional STACK_POP_ABORT_EN adds an abort input that cancels an active unwind.
module stack_pop_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int CNT_W  = STACK_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CNT_W-1:0]  req_count,
    input  logic [CNT_W-1:0]  stk_level,
    input  logic [DATA_W-1:0] stk_top,
    output logic              stk_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
`ifdef STACK_POP_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              err_underflow
);
    stack_pop_state_t  r_state;
    logic [CNT_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_err;
    logic              r_armed;
    logic              w_abort;
    logic              w_req_hs;
    logic              w_too_many;
    logic              w_pop;

`ifdef STACK_POP_ABORT_EN
    assign w_abort = abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // r_armed keeps req_ready low while reset is asserted
    assign req_ready     = r_armed && (r_state == IDLE);
    assign w_req_hs      = req_valid && req_ready;
    assign w_too_many    = (req_count > stk_level) || (32'(req_count) > DEPTH);
    assign w_pop         = (r_state == CAPTURE) && (stk_level != '0) && !w_abort;
    assign stk_pop       = w_pop;
    assign out_valid     = (r_state == PRESENT);
    assign out_data      = r_out_data;
    assign out_last      = r_out_last;
    assign busy          = (r_state != IDLE);
    assign err_underflow = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_abort) begin
                r_state     <= IDLE;
                r_remaining <= '0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_req_hs && (req_count != '0)) begin
                            if (w_too_many) begin
                                r_err <= 1'b1;
                            end else begin
                                r_remaining <= req_count;
                                r_state     <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        // stack emptied underneath us: abandon rather than pop an empty stack
                        if (stk_level == '0) begin
                            r_err       <= 1'b1;
                            r_remaining <= '0;
                            r_state     <= IDLE;
                        end else begin
                            r_out_data  <= stk_top;
                            r_remaining <= r_remaining - 1'b1;
                            r_out_last  <= (r_remaining == CNT_W'(1));
                            r_state     <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (out_ready) begin
                            if (r_out_last) begin
                                r_out_last <= 1'b0;
                                r_state    <= IDLE;
                            end else begin
                                r_state <= SETTLE;
                            end
                        end
                    end
                    SETTLE:  r_state <= CAPTURE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stack_pop_ctrl.sv
// Directed bench for stack_pop_ctrl with a behavioural stack model.
module tb_stack_pop_ctrl;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_count = '0;
    logic [3:0]  stk_level;
    logic [31:0] stk_top;
    logic        stk_pop;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err_underflow;
`ifdef STACK_POP_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int pop_cnt = 0;
    int pop_base = 0;
    int load_level = 0;
    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    always @(posedge clk) if (stk_pop) pop_cnt++;

    always_comb begin
        stk_level = 4'(load_level - (pop_cnt - pop_base));
        stk_top   = (stk_level != 0) ? mem[stk_level - 1] : 32'd0;
    end

    stack_pop_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_count(req_count),
        .stk_level(stk_level), .stk_top(stk_top), .stk_pop(stk_pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last),
`ifdef STACK_POP_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int n);
        mem[0] = a; mem[1] = b; mem[2] = c;
        pop_base = pop_cnt;
        load_level = n;
    endtask

    // one request handshake, then leave req_valid low
    task automatic request(input logic [3:0] cnt);
        req_count = cnt;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // wait (bounded) for a beat, check it, and accept it with out_ready=1
    task automatic beat(input string tag, input logic [31:0] d, input logic l);
        int k = 0;
        while (!out_valid && k < 8) begin tick(); k++; end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_last"}, 32'(out_last), 32'(l));
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // reset state
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stk_pop", 32'(stk_pop), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        chk("rel_err", 32'(err_underflow), 32'd0);

        // two-word unwind with exact latencies
        load3(32'd5, 32'd6, 32'd7, 3);
        out_ready = 1'b1;
        request(4'd2);
        chk("t1_capture_pop", 32'(stk_pop), 32'd1);
        chk("t1_capture_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t1_b0_valid", 32'(out_valid), 32'd1);
        chk("t1_b0_data", out_data, 32'd7);
        chk("t1_b0_last", 32'(out_last), 32'd0);
        chk("t1_level_after_pop", 32'(stk_level), 32'd2);
        tick();
        chk("t1_settle_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t1_capture2_pop", 32'(stk_pop), 32'd1);
        tick();
        chk("t1_b1_valid", 32'(out_valid), 32'd1);
        chk("t1_b1_data", out_data, 32'd6);
        chk("t1_b1_last", 32'(out_last), 32'd1);
        tick();
        chk("t1_done_valid", 32'(out_valid), 32'd0);
        chk("t1_done_busy", 32'(busy), 32'd0);
        chk("t1_level_end", 32'(stk_level), 32'd1);
        chk("t1_pops", 32'(pop_cnt - pop_base), 32'd2);

        // backpressure on the first beat
        load3(32'hA1, 32'hB2, 32'hC3, 3);
        out_ready = 1'b0;
        request(4'd3);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) begin
                chk("bp_hold_data", out_data, 32'hC3);
                chk("bp_hold_pops", 32'(pop_cnt - pop_base), 32'd1);
            end
            tick();
        end
        chk("bp_still_valid", 32'(out_valid), 32'd1);
        beat("bp_b0", 32'hC3, 1'b0);
        beat("bp_b1", 32'hB2, 1'b0);
        beat("bp_b2", 32'hA1, 1'b1);
        chk("bp_pops", 32'(pop_cnt - pop_base), 32'd3);
        chk("bp_idle", 32'(busy), 32'd0);

        // underflow: more requested than held
        load3(32'h11, 32'h22, 32'h0, 2);
        p0 = pop_cnt;
        request(4'd3);
        chk("uf_err", 32'(err_underflow), 32'd1);
        chk("uf_busy", 32'(busy), 32'd0);
        tick(); tick();
        chk("uf_no_pop", 32'(pop_cnt - p0), 32'd0);
        chk("uf_sticky", 32'(err_underflow), 32'd1);
        request(4'd1);
        beat("uf_after", 32'h22, 1'b1);
        chk("uf_after_err", 32'(err_underflow), 32'd1);
        chk("uf_after_level", 32'(stk_level), 32'd1);

        // zero-count request is a no-op
        p0 = pop_cnt;
        request(4'd0);
        chk("z_busy", 32'(busy), 32'd0);
        tick(); tick();
        chk("z_valid", 32'(out_valid), 32'd0);
        chk("z_pops", 32'(pop_cnt - p0), 32'd0);
        chk("z_ready", 32'(req_ready), 32'd1);

`ifdef STACK_POP_ABORT_EN
        load3(32'h31, 32'h32, 32'h33, 3);
        out_ready = 1'b0;
        request(4'd3);
        tick();
        chk("ab_present", 32'(out_valid), 32'd1);
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_level", 32'(stk_level), 32'd2);
        tick(); tick(); tick();
        chk("ab_no_more_pops", 32'(stk_level), 32'd2);
`endif

        // reset while a word is held in PRESENT
        load3(32'h41, 32'h42, 32'h43, 3);
        out_ready = 1'b0;
        request(4'd2);
        tick();
        chk("mr_present", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data", out_data, 32'd0);
        chk("mr_last", 32'(out_last), 32'd0);
        chk("mr_err", 32'(err_underflow), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_pop", 32'(stk_pop), 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_rel_ready", 32'(req_ready), 32'd1);
        chk("mr_rel_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
